// File: rtl/spi_flash_responder.sv
// rtl/spi_flash_responder.sv - SPI NOR flash responder: status, read, page program, status write, sector erase
module spi_flash_responder #(
  parameter int MEM_AW       = 8,
  parameter int PROG_CYCLES  = 64,
  parameter int ERASE_CYCLES = 512
) (
  input  logic clk,
  input  logic rst,
  input  logic SCK,
  input  logic CSbar,
  input  logic DI,
  output logic DO,
  output logic busy,
  output logic wel
);
  localparam int MAXC = (ERASE_CYCLES > PROG_CYCLES) ? ERASE_CYCLES : PROG_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  localparam logic [CW-1:0] PROG_LD  = CW'(PROG_CYCLES);
  localparam logic [CW-1:0] ERASE_LD = CW'(ERASE_CYCLES);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_RDATA, S_RSTAT, S_WDATA, S_WSR, S_IGNORE
  } state_t;

  state_t state, state_next;

  logic sck_s1, sck_s2, sck_d, cs_s1, cs_s2, cs_d, di_s1, di_s2;
  logic sck_rise, cs_rise, cs_fall, bit_rise;
  logic [7:0] mem [2**MEM_AW];
  logic [6:0] in_sh;
  logic [7:0] tx_sh, opcode, byte_in, status, mem_wd;
  logic [4:0] bit_cnt;
  logic [MEM_AW-1:0] addr, addr_in, addr_inc, erase_ptr, mem_wa;
  logic [CW-1:0] busy_cnt;
  logic arm_wel, arm_erase, wrote, wsr_full, erasing, mem_we;

  assign sck_rise = sck_s2 & ~sck_d;
  assign cs_rise  = cs_s2 & ~cs_d;
  assign cs_fall  = ~cs_s2 & cs_d;
  // a bit is only taken once chip select has been low for a full cycle
  assign bit_rise = sck_rise & ~cs_s2 & ~cs_d;
  assign byte_in  = {in_sh, di_s2};
  assign addr_in  = {addr[MEM_AW-2:0], di_s2};
  assign addr_inc = addr + 1'b1;
  assign status   = {6'b0, wel, busy};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sck_s1 <= 1'b1; sck_s2 <= 1'b1; sck_d <= 1'b1;
      cs_s1  <= 1'b1; cs_s2  <= 1'b1; cs_d  <= 1'b1;
      di_s1  <= 1'b0; di_s2  <= 1'b0;
    end else begin
      sck_s1 <= SCK;   sck_s2 <= sck_s1; sck_d <= sck_s2;
      cs_s1  <= CSbar; cs_s2  <= cs_s1;  cs_d  <= cs_s2;
      di_s1  <= DI;    di_s2  <= di_s1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (cs_rise) begin
      state_next = S_IDLE;
    end else if (cs_fall) begin
      state_next = S_CMD;
    end else if (bit_rise) begin
      case (state)
        S_CMD: if (bit_cnt == 5'd7) begin
          if (busy && byte_in != 8'h05) state_next = S_IGNORE;
          else begin
            case (byte_in)
              8'h05:               state_next = S_RSTAT;
              8'h01:               state_next = S_WSR;
              8'h02, 8'h03, 8'h20: state_next = S_ADDR;
              default:             state_next = S_IGNORE;
            endcase
          end
        end
        S_ADDR: if (bit_cnt == 5'd23) begin
          if (opcode == 8'h03)      state_next = S_RDATA;
          else if (opcode == 8'h02) state_next = S_WDATA;
          else                      state_next = S_IGNORE;
        end
        default: state_next = state;
      endcase
    end
  end

  // Erase owns the write port while it runs; busy keeps program writes out of that window.
  always_comb begin
    mem_we = 1'b0;
    mem_wa = addr;
    mem_wd = mem[addr] & byte_in;
    if (erasing) begin
      mem_we = 1'b1;
      mem_wa = erase_ptr;
      mem_wd = 8'hFF;
    end else if (bit_rise && state == S_WDATA && bit_cnt[2:0] == 3'd7 && wel) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      DO <= 1'b0; tx_sh <= '0; in_sh <= '0; bit_cnt <= '0; opcode <= '0; addr <= '0;
      arm_wel <= 1'b0; arm_erase <= 1'b0; wrote <= 1'b0; wsr_full <= 1'b0;
      busy <= 1'b0; wel <= 1'b0; busy_cnt <= '0; erasing <= 1'b0; erase_ptr <= '0;
    end else begin
      if (busy) begin
        busy_cnt <= busy_cnt - 1'b1;
        if (busy_cnt == CNT_ONE) begin
          busy <= 1'b0;
          wel  <= 1'b0;
        end
      end
      if (erasing) begin
        erase_ptr <= erase_ptr + 1'b1;
        if (&erase_ptr) erasing <= 1'b0;
      end
      if (cs_rise) begin
        DO <= 1'b0;
        tx_sh <= '0;
        if (arm_wel) wel <= 1'b1;
        // a program only commits when chip select rises on a byte boundary
        if (wel && ((state == S_WSR && wsr_full) ||
                    (state == S_WDATA && wrote && bit_cnt[2:0] == 3'd0))) begin
          busy <= 1'b1;
          busy_cnt <= PROG_LD;
        end
        if (wel && arm_erase) begin
          busy <= 1'b1;
          busy_cnt <= ERASE_LD;
          erasing <= 1'b1;
          erase_ptr <= '0;
        end
        arm_wel <= 1'b0;
        arm_erase <= 1'b0;
      end else if (cs_fall) begin
        bit_cnt <= '0; arm_wel <= 1'b0; arm_erase <= 1'b0;
        wrote <= 1'b0; wsr_full <= 1'b0; DO <= 1'b0; tx_sh <= '0;
      end else if (bit_rise) begin
        in_sh <= byte_in[6:0];
        bit_cnt <= bit_cnt + 1'b1;
        case (state)
          S_CMD: if (bit_cnt == 5'd7) begin
            bit_cnt <= '0;
            opcode <= byte_in;
            arm_wel <= (byte_in == 8'h06) && !busy;
            if (state_next == S_RSTAT) begin
              DO <= status[7];
              tx_sh <= {status[6:0], 1'b0};
            end
          end
          S_ADDR: begin
            addr <= addr_in;
            if (bit_cnt == 5'd23) begin
              bit_cnt <= '0;
              if (opcode == 8'h03) begin
                DO <= mem[addr_in][7];
                tx_sh <= {mem[addr_in][6:0], 1'b0};
              end
              if (opcode == 8'h20) arm_erase <= 1'b1;
            end
          end
          S_RSTAT: begin
            if (bit_cnt[2:0] == 3'd7) begin
              DO <= status[7];
              tx_sh <= {status[6:0], 1'b0};
            end else begin
              DO <= tx_sh[7];
              tx_sh <= {tx_sh[6:0], 1'b0};
            end
          end
          S_RDATA: begin
            if (bit_cnt[2:0] == 3'd7) begin
              addr <= addr_inc;
              DO <= mem[addr_inc][7];
              tx_sh <= {mem[addr_inc][6:0], 1'b0};
            end else begin
              DO <= tx_sh[7];
              tx_sh <= {tx_sh[6:0], 1'b0};
            end
          end
          S_WDATA: if (bit_cnt[2:0] == 3'd7) begin
            addr <= addr_inc;
            if (wel) wrote <= 1'b1;
          end
          S_WSR: if (bit_cnt[2:0] == 3'd7) wsr_full <= 1'b1;
          S_IGNORE: begin
            arm_wel <= 1'b0;
            arm_erase <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_spi_flash_responder.sv
// tb/tb_spi_flash_responder.sv - self-checking bench for spi_flash_responder
module tb_spi_flash_responder;
  logic clk, rst, SCK, CSbar, DI, DO, busy, wel;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int cs_rise_cyc = 0;
  logic [7:0] txb [16];
  logic [7:0] rxb [16];
  logic [7:0] pdata [3];
  logic [7:0] mm [256];
  logic model_wel = 1'b0;

  spi_flash_responder #(.MEM_AW(8), .PROG_CYCLES(64), .ERASE_CYCLES(512)) dut (
    .clk(clk), .rst(rst), .SCK(SCK), .CSbar(CSbar), .DI(DI),
    .DO(DO), .busy(busy), .wel(wel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_tx();
    for (int k = 0; k < 16; k++) txb[k] = 8'h00;
  endtask

  // mode 3 initiator: DI changes on the falling edge, DO is sampled just before each rising edge
  task automatic spi_xfer(input int nbits);
    for (int k = 0; k < 16; k++) rxb[k] = 8'h00;
    @(negedge clk);
    CSbar = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      SCK = 1'b0;
      DI = txb[i / 8][7 - (i % 8)];
      repeat (2) @(negedge clk);
      rxb[i / 8][7 - (i % 8)] = DO;
      SCK = 1'b1;
      repeat (2) @(negedge clk);
    end
    CSbar = 1'b1;
    cs_rise_cyc = cyc;
    repeat (6) @(negedge clk);
  endtask

  task automatic status_chk(input string tag, input logic [7:0] exp);
    clr_tx();
    txb[0] = 8'h05;
    spi_xfer(16);
    check({tag, "_do_during_cmd"}, rxb[0], 8'h00);
    check(tag, rxb[1], exp);
    check({tag, "_do_after"}, DO, 1'b0);
  endtask

  task automatic wren();
    clr_tx();
    txb[0] = 8'h06;
    spi_xfer(8);
    model_wel = 1'b1;
  endtask

  task automatic read_chk(input string tag, input logic [7:0] a, input int n);
    logic [7:0] idx;
    clr_tx();
    txb[0] = 8'h03;
    txb[3] = a;
    spi_xfer(32 + 8 * n);
    for (int k = 0; k < n; k++) begin
      idx = a + 8'(k);
      check($sformatf("%s_byte%0d", tag, k), rxb[4 + k], mm[idx]);
    end
  endtask

  task automatic prog(input logic [7:0] a, input int n);
    logic [7:0] idx;
    clr_tx();
    txb[0] = 8'h02;
    txb[3] = a;
    for (int k = 0; k < n; k++) txb[4 + k] = pdata[k];
    spi_xfer(32 + 8 * n);
    if (model_wel)
      for (int k = 0; k < n; k++) begin
        idx = a + 8'(k);
        mm[idx] = mm[idx] & pdata[k];
      end
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_busy_clears"}, busy, 1'b0);
    model_wel = 1'b0;
  endtask

  initial begin
    int el, nb, n, op;
    logic [7:0] a;
    rst = 1'b0; SCK = 1'b1; CSbar = 1'b1; DI = 1'b0;
    repeat (4) @(negedge clk);
    check("reset_do", DO, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_wel", wel, 1'b0);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    status_chk("stat_after_reset", 8'h00);
    clr_tx();
    txb[0] = 8'h06;
    spi_xfer(5);
    status_chk("stat_wren_abort5", 8'h00);
    wren();
    check("wel_pin_after_wren", wel, 1'b1);
    status_chk("stat_wel_set", 8'h02);

    // sector erase, with the busy-window behaviour exercised while it runs
    clr_tx();
    txb[0] = 8'h20;
    spi_xfer(32);
    el = cs_rise_cyc;
    for (int k = 0; k < 256; k++) mm[k] = 8'hFF;
    check("erase_busy_set", busy, 1'b1);
    status_chk("stat_erasing", 8'h03);
    clr_tx();
    txb[0] = 8'h03;
    txb[3] = 8'h10;
    spi_xfer(40);
    check("read_while_busy_do_zero", rxb[0] | rxb[1] | rxb[2] | rxb[3] | rxb[4], 8'h00);
    clr_tx();
    txb[0] = 8'h06;
    spi_xfer(8);
    check("wel_while_busy", wel, 1'b1);
    status_chk("stat_erasing_after_wren", 8'h03);
    wait_idle("erase");
    el = cyc - el;
    check($sformatf("erase_len_%0d_in_window", el), (el >= 512 && el <= 518), 1'b1);
    check("wel_cleared_after_erase", wel, 1'b0);
    status_chk("stat_after_erase", 8'h00);
    read_chk("rd_wrap_erased", 8'hFE, 4);

    wren();
    pdata[0] = 8'hA5;
    pdata[1] = 8'h3C;
    prog(8'hFF, 2);
    el = cs_rise_cyc;
    check("prog_busy_set", busy, 1'b1);
    wait_idle("prog_a53c");
    el = cyc - el;
    check($sformatf("prog_len_%0d_in_window", el), (el >= 64 && el <= 70), 1'b1);
    read_chk("rd_a53c", 8'hFF, 2);

    wren();
    pdata[0] = 8'h0F;
    prog(8'hFF, 1);
    wait_idle("prog_0f");
    read_chk("rd_and_05", 8'hFF, 1);
    check("rd_and_05_const", rxb[4], 8'h05);

    pdata[0] = 8'h00;
    prog(8'hFF, 1);
    check("prog_no_wren_busy", busy, 1'b0);
    read_chk("rd_no_wren", 8'hFF, 1);

    for (int it = 0; it < 10; it++) begin
      op = $urandom_range(0, 2);
      if (op == 0) begin
        nb = $urandom_range(1, 14);
        if (nb >= 8) nb++;
        clr_tx();
        txb[0] = 8'h06;
        txb[1] = 8'($urandom);
        spi_xfer(nb);
        status_chk($sformatf("rnd%0d_wren_%0dbits", it, nb), {6'b0, model_wel, 1'b0});
      end else begin
        a = 8'($urandom);
        n = (op == 1) ? $urandom_range(1, 3) : 1;
        for (int k = 0; k < 3; k++) pdata[k] = 8'($urandom);
        if (op == 1) wren();
        prog(a, n);
        check($sformatf("rnd%0d_busy", it), busy, model_wel);
        wait_idle($sformatf("rnd%0d", it));
        read_chk($sformatf("rnd%0d_rd", it), a, n);
      end
    end

    wren();
    clr_tx();
    txb[0] = 8'h01;
    txb[1] = 8'h9C;
    spi_xfer(16);
    check("wsr_busy_set", busy, 1'b1);
    wait_idle("wsr");
    status_chk("stat_after_wsr", 8'h00);

    wren();
    clr_tx();
    txb[0] = 8'h01;
    spi_xfer(16);
    check("wsr2_busy_set", busy, 1'b1);
    rst = 1'b0;
    #2;
    check("rst_mid_busy_busy", busy, 1'b0);
    check("rst_mid_busy_wel", wel, 1'b0);
    check("rst_mid_busy_do", DO, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    status_chk("stat_after_rst_mid_busy", 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/spi_flash_responder.md
SPI_FLASH_RESPONDER -- requirements
Module: spi_flash_responder

Interface
REQ-001 Parameter MEM_AW, default 8, memory address width; the array holds 2^MEM_AW bytes.
REQ-002 Parameter PROG_CYCLES, default 64, busy duration in clk cycles for program and write-status.
REQ-003 Parameter ERASE_CYCLES, default 512, busy duration for sector erase; must be at least 2^MEM_AW.
REQ-004 clk  input  1  single system clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 SCK  input  1  SPI clock from the initiator (mode 3, idle high); asynchronous to clk.
REQ-007 CSbar  input  1  active-low chip select from the initiator.
REQ-008 DI  input  1  serial data from the initiator, MSB first.
REQ-009 DO  output  1  serial data to the initiator, MSB first; registered.
REQ-010 busy  output  1  status bit0 (WIP).
REQ-011 wel  output  1  status bit1 (write-enable latch).

Function
REQ-012 SCK, CSbar and DI SHALL each pass through a 2-flop synchronizer; SCK edges are detected on the synchronized signal.
REQ-013 SCK high and low phases SHALL each be at least 2 clk cycles; shorter phases are unsupported.
REQ-014 DI SHALL be sampled on each detected SCK rising edge while CSbar (synchronized) is low.
REQ-015 DO SHALL update on the clk cycle after a detected SCK rising edge, i.e. 3 clk after the pin edge, and holds through the next rising edge.
REQ-016 DO SHALL be 0 whenever no response byte is being shifted.
REQ-017 A synchronized CSbar falling edge SHALL clear the bit counter and enter CMD.
REQ-018 FSM states: IDLE, CMD, ADDR, RDATA, RSTAT, WDATA, WSR, IGNORE.
REQ-019 CMD: after 8 bits, decode as follows:
  - 05 -> RSTAT
  - 06 -> IGNORE, with WEL armed
  - 01 -> WSR
  - 02, 03, 20 -> ADDR
  - any other opcode -> IGNORE
REQ-020 While busy=1, every opcode other than 05 SHALL go to IGNORE with no side effects.
REQ-021 ADDR: collect 24 bits, keeping the low MEM_AW bits. Then go to RDATA for 03, WDATA for 02, or IGNORE (erase armed) for 20.
REQ-022 RSTAT: repeatedly shift {6'b0, wel, busy}, with the first bit driven at the update following the 8th opcode bit.
REQ-023 RDATA: shift mem[addr], with the first bit driven at the update following the 24th address bit. Increment addr after each byte, wrapping modulo 2^MEM_AW. Continue until CSbar rises.
REQ-024 WDATA: on each completed byte, if wel=1, write mem[addr] <= mem[addr] & byte, then increment addr wrapping modulo 2^MEM_AW. Partial bytes are discarded.
REQ-025 WSR: the first complete byte is held; further bits are ignored.
REQ-026 A synchronized CSbar rising edge SHALL return the FSM to IDLE and commit an armed action only when its exact bit count was met:
  - 06 after exactly 8 bits: set wel.
  - 01 with wel=1 and at least 8 data bits: set busy for PROG_CYCLES; the held byte is discarded (no writable bits).
  - 02 with wel=1 and at least one byte written: set busy for PROG_CYCLES.
  - 20 with wel=1 and exactly 24 address bits: set busy for ERASE_CYCLES and erase.
REQ-027 Erase SHALL write 8'hFF to one byte per clk, address 0 upward, during the first 2^MEM_AW busy cycles.
REQ-028 When the busy counter expires, busy and wel SHALL clear on the same clk.
REQ-029 CSbar rising mid-byte or mid-address SHALL abort with no commit; bytes already programmed remain.
REQ-030 CSbar falling while busy SHALL NOT affect the busy counter.

Reset
REQ-031 On rst=0: FSM=IDLE, DO=0, busy=0, wel=0, counters=0, synchronizers=1 (CSbar, SCK) and 0 (DI). Memory contents are not reset.
REQ-032 Reset mid-transaction or mid-busy SHALL abort immediately; a partially erased array keeps its partial state.

Verification
REQ-033 Reset, then read status (05) with SCK=clk/4 -> byte 8'h00; DO=0 before and after.
REQ-034 06, then 05 -> status 8'h02; 06 aborted after 5 bits, then 05 -> 8'h00.
REQ-035 06, 20 addr 000000; poll 05 -> 8'h03 until ERASE_CYCLES, then 8'h00; 03 addr 0000FE with 4 bytes read -> FF,FF,FF,FF (wraps FE,FF,00,01).
REQ-036 After erase: 06, 02 addr 0000FF, data A5,3C, CS rise; poll busy clear; 03 addr 0000FF with 2 bytes read -> A5,3C.
REQ-037 Program 0F over A5 at addr 0000FF (with 06) -> readback 05; 02 without 06 -> memory unchanged, busy stays 0.
REQ-038 During busy: 03 -> DO stays 0; 06 -> wel unchanged; 05 -> 8'h03.
